// File: rtl/f_regfile.sv
// ---------------------------------------------------------------------------
// f_regfile -- floating-point register file with write-through bypass
//
// 32 x DW-bit registers, all writable (no hardwired zero). Two combinational
// read ports; one write port whose format (single/double) is chosen by cop.
// A single-precision write replaces only the low 32 bits and keeps the upper
// half. While a write is in flight, a read of the same index returns the
// value the register will hold after the edge, so a consumer in the same
// cycle never sees stale data. A registered FP condition flag (fcc) and a
// per-register "written since reset" mask (f_valid) live alongside.
//
// There are no valid/ready handshakes here: f_reg_write and fcc_we are plain
// single-cycle enables, each committing on the rising edge it is sampled
// high with reset low. They are independent and may commit together.
//
// Ports
//   clk           in   1   rising-edge clock
//   reset         in   1   synchronous, active-high; beats any write
//   read_f_reg1   in   5   operand 1 source index
//   read_f_reg2   in   5   operand 2 source index
//   write_f_reg   in   5   destination index
//   write_f_data  in   DW  write-back data
//   f_reg_write   in   1   register write enable
//   cop           in   5   5'b10000 = single, anything else = full width
//   fcc_we        in   1   condition-flag write enable
//   fcc_in        in   1   condition-flag value
//   read_f_data1  out  DW  operand 1 (bypassed)
//   read_f_data2  out  DW  operand 2 (bypassed)
//   fcc           out  1   registered condition flag
//   f_valid       out  32  per-register written-since-reset mask
// ---------------------------------------------------------------------------
module f_regfile #(
  parameter int NREGS = 32,
  parameter int DW    = 64
) (
  input  logic          clk,
  input  logic          reset,
  input  logic [4:0]    read_f_reg1,
  input  logic [4:0]    read_f_reg2,
  input  logic [4:0]    write_f_reg,
  input  logic [DW-1:0] write_f_data,
  input  logic          f_reg_write,
  input  logic [4:0]    cop,
  input  logic          fcc_we,
  input  logic          fcc_in,
  output logic [DW-1:0] read_f_data1,
  output logic [DW-1:0] read_f_data2,
  output logic          fcc,
  output logic [31:0]   f_valid
);

  localparam logic [4:0] COP_SINGLE = 5'b10000;

  // The array always spans the full 5-bit address space so every read index
  // is in range and returns a defined value. Indices at or above NREGS are
  // simply never written and read back as zero.
  localparam logic [31:0] WR_MASK = (NREGS >= 32) ? 32'hFFFF_FFFF
                                                  : 32'((64'h1 << NREGS) - 64'h1);

  logic [DW-1:0] regs [32];
  logic [DW-1:0] wr_old;
  logic [DW-1:0] wr_merged;
  logic          wr_commit;
  logic          byp_en;

  // Value the destination register will hold after this edge.
  always_comb begin
    wr_old = regs[write_f_reg];
    if (cop == COP_SINGLE) begin
      wr_merged = {wr_old[DW-1:32], write_f_data[31:0]};
    end else begin
      wr_merged = write_f_data;
    end
  end

  assign wr_commit = f_reg_write && WR_MASK[write_f_reg];
  // Reset suppresses the bypass because the write is about to be discarded.
  assign byp_en    = wr_commit && !reset;

  always_comb begin
    read_f_data1 = regs[read_f_reg1];
    read_f_data2 = regs[read_f_reg2];
    if (byp_en && (read_f_reg1 == write_f_reg)) begin
      read_f_data1 = wr_merged;
    end
    if (byp_en && (read_f_reg2 == write_f_reg)) begin
      read_f_data2 = wr_merged;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) begin
        regs[i] <= '0;
      end
      fcc     <= 1'b0;
      f_valid <= '0;
    end else begin
      if (wr_commit) begin
        regs[write_f_reg]    <= wr_merged;
        f_valid[write_f_reg] <= 1'b1;
      end
      if (fcc_we) begin
        fcc <= fcc_in;
      end
    end
  end

endmodule
